// File: rtl/cla_nibble_seq_adder.sv
// Sequential WIDTH-bit adder: one 4-bit carry-lookahead slice is reused
// for every nibble, LSB first, with the nibble carry held in a register
// between cycles. Result is complete on the cycle done pulses.

// 4-bit carry-lookahead slice: carries are flat sum-of-products of g/p,
// so no carry ripples through the nibble.
module cla_nibble_slice (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_c0,
    output logic [3:0] o_s,
    output logic       o_c3,
    output logic       o_c4
);
    logic [3:0] w_g, w_p;
    logic       w_c1, w_c2, w_c3, w_c4;

    assign w_g  = i_a & i_b;
    assign w_p  = i_a ^ i_b;
    assign w_c1 = w_g[0] | (w_p[0] & i_c0);
    assign w_c2 = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_c0);
    assign w_c3 = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & i_c0);
    assign w_c4 = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_c0);
    assign o_s  = w_p ^ {w_c3, w_c2, w_c1, i_c0};
    assign o_c3 = w_c3;
    assign o_c4 = w_c4;
endmodule

module cla_nibble_seq_adder #(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout,
    output logic             o_ovf
);
    localparam int NIBBLES = WIDTH / 4;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_ADD, S_DONE} state_t;

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_a, r_b, r_sum;
    logic [IDX_W-1:0] r_idx;
    logic             r_carry, r_busy, r_done, r_cout, r_ovf;

    logic [3:0]       w_sa, w_sb, w_ss;
    logic             w_c3, w_c4, w_accept, w_last;

    // start is honoured only outside ADD, so an in-flight add can't be disturbed
    assign w_accept = i_start && (r_state != S_ADD);
    assign w_last   = (r_idx == LAST_IDX);
    assign w_sa     = r_a[{r_idx, 2'b00} +: 4];
    assign w_sb     = r_b[{r_idx, 2'b00} +: 4];

    cla_nibble_slice u_slice (
        .i_a  (w_sa),
        .i_b  (w_sb),
        .i_c0 (r_carry),
        .o_s  (w_ss),
        .o_c3 (w_c3),
        .o_c4 (w_c4)
    );

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_state_nxt = S_ADD;
            S_ADD:   if (w_last)  w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = i_start ? S_ADD : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath: operand capture, one nibble per ADD cycle, registered flags
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            // flags follow the next state so busy/done are true registers
            r_busy <= (w_state_nxt == S_ADD);
            r_done <= (w_state_nxt == S_DONE);
            if (w_accept) begin
                r_a     <= i_a;
                r_b     <= i_b;
                r_carry <= i_cin;
                r_idx   <= '0;
                r_sum   <= '0;
                r_cout  <= 1'b0;
                r_ovf   <= 1'b0;
            end else if (r_state == S_ADD) begin
                r_sum[{r_idx, 2'b00} +: 4] <= w_ss;
                r_carry <= w_c4;
                r_idx   <= r_idx + 1'b1;
                if (w_last) begin
                    r_cout <= w_c4;
                    r_ovf  <= w_c3 ^ w_c4;
                end
            end
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_sum  = r_sum;
    assign o_cout = r_cout;
    assign o_ovf  = r_ovf;
endmodule

// File: tb/tb_cla_nibble_seq_adder.sv
// Scoreboard bench: three adder instances (WIDTH 16, 8, 32) share one clock.
// Expected sum/cout/ovf and the done cycle are queued at launch and checked
// when done pulses.
module tb_cla_nibble_seq_adder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          cyc = 0;
    int          n_chk = 0;
    int          n_err = 0;

    logic        start_v [3];
    logic [31:0] a_v     [3];
    logic [31:0] b_v     [3];
    logic        cin_v   [3];
    logic        busy_v  [3];
    logic        done_v  [3];
    logic [31:0] sum_v   [3];
    logic        cout_v  [3];
    logic        ovf_v   [3];

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        int          due;
    } exp_t;

    exp_t q0[$], q1[$], q2[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int wid(input int i);
        return (i == 0) ? 16 : ((i == 1) ? 8 : 32);
    endfunction

    function automatic int qsize(input int i);
        case (i)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic void qpush(input int i, input exp_t e);
        case (i)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endfunction

    function automatic exp_t qpop(input int i);
        case (i)
            0:       return q0.pop_front();
            1:       return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    function automatic void qflush(input int i);
        case (i)
            0:       q0.delete();
            1:       q1.delete();
            default: q2.delete();
        endcase
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int W = (g == 0) ? 16 : ((g == 1) ? 8 : 32);
        logic [W-1:0] w_sum;

        cla_nibble_seq_adder #(.WIDTH(W)) u_dut (
            .i_clk   (clk),
            .i_rst_n (rst_n),
            .i_start (start_v[g]),
            .i_a     (a_v[g][W-1:0]),
            .i_b     (b_v[g][W-1:0]),
            .i_cin   (cin_v[g]),
            .o_busy  (busy_v[g]),
            .o_done  (done_v[g]),
            .o_sum   (w_sum),
            .o_cout  (cout_v[g]),
            .o_ovf   (ovf_v[g])
        );
        assign sum_v[g] = 32'(w_sum);

        // Sample away from the active edge; every done must match a queued result
        always @(negedge clk) begin
            exp_t e;
            chk($sformatf("busy_and_done_w%0d", W), busy_v[g] & done_v[g], 0);
            if (done_v[g]) begin
                if (qsize(g) == 0) begin
                    chk($sformatf("spurious_done_w%0d", W), 1, 0);
                end else begin
                    e = qpop(g);
                    chk($sformatf("sum_w%0d", W),     sum_v[g],  e.sum);
                    chk($sformatf("cout_w%0d", W),    cout_v[g], e.cout);
                    chk($sformatf("ovf_w%0d", W),     ovf_v[g],  e.ovf);
                    chk($sformatf("latency_w%0d", W), cyc,       e.due);
                end
            end
        end
    end

    // Called at a negedge; start is held across exactly one rising edge.
    task automatic launch(input int i, input logic [31:0] a, input logic [31:0] b,
                          input logic cin, input bit accept);
        exp_t        e;
        int          w;
        logic [63:0] m, full;
        w    = wid(i);
        m    = (64'd1 << w) - 64'd1;
        full = ({32'd0, a} & m) + ({32'd0, b} & m) + {63'd0, cin};
        e.sum  = full[31:0] & m[31:0];
        e.cout = full[w];
        e.ovf  = (a[w-1] == b[w-1]) && (e.sum[w-1] != a[w-1]);
        e.due  = cyc + 1 + w / 4;
        a_v[i]     = a & m[31:0];
        b_v[i]     = b & m[31:0];
        cin_v[i]   = cin;
        start_v[i] = 1'b1;
        if (accept) qpush(i, e);
        @(negedge clk);
        start_v[i] = 1'b0;
    endtask

    // Returns at the negedge where done is seen (state DONE).
    task automatic wait_done(input int i);
        for (int t = 0; t < 40; t++) begin
            if (done_v[i]) return;
            @(negedge clk);
        end
        chk($sformatf("timeout_inst%0d", i), 0, 1);
        qflush(i);
    endtask

    logic [31:0] vec_a [6] = '{32'h0001, 32'hFFFF, 32'h0FFF, 32'h7FFF, 32'h8000, 32'hFFFF};
    logic [31:0] vec_b [6] = '{32'h0002, 32'h0000, 32'h0001, 32'h0001, 32'h8000, 32'hFFFF};
    logic        vec_c [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        for (int i = 0; i < 3; i++) begin
            start_v[i] = 1'b0; a_v[i] = '0; b_v[i] = '0; cin_v[i] = 1'b0;
        end
        repeat (2) @(negedge clk);
        chk("rst_busy", busy_v[0], 0);
        chk("rst_done", done_v[0], 0);
        chk("rst_sum",  sum_v[0],  0);
        chk("rst_cout", cout_v[0], 0);
        chk("rst_ovf",  ovf_v[0],  0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1 + 2 with busy/done timing: busy after edges k..k+3, done after k+4
        launch(0, vec_a[0], vec_b[0], vec_c[0], 1);
        for (int j = 0; j < 4; j++) begin
            chk("busy_window", busy_v[0], 1);
            chk("done_early",  done_v[0], 0);
            @(negedge clk);
        end
        chk("done_at_k4", done_v[0], 1);
        chk("busy_at_k4", busy_v[0], 0);
        @(negedge clk);
        chk("done_one_cycle", done_v[0], 0);

        // carry chains and overflow corners
        for (int v = 1; v < 6; v++) begin
            launch(0, vec_a[v], vec_b[v], vec_c[v], 1);
            wait_done(0);
            @(negedge clk);
        end

        // start during ADD is ignored; first result must be unchanged
        launch(0, 32'h1111, 32'h2222, 1'b0, 1);
        launch(0, 32'h5555, 32'h6666, 1'b1, 0);
        wait_done(0);
        repeat (6) @(negedge clk);

        // start in the DONE cycle is accepted back-to-back
        launch(0, 32'h1234, 32'h0FF0, 1'b0, 1);
        wait_done(0);
        launch(0, 32'hA5A5, 32'h5A5B, 1'b1, 1);
        chk("b2b_done_low", done_v[0], 0);
        chk("b2b_busy_high", busy_v[0], 1);
        wait_done(0);
        @(negedge clk);

        // reset during the second ADD cycle discards the add
        launch(0, 32'h1234, 32'h4321, 1'b0, 1);
        @(negedge clk);
        rst_n = 1'b0;
        qflush(0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_busy", busy_v[0], 0);
        chk("midrst_done", done_v[0], 0);
        chk("midrst_sum",  sum_v[0],  0);
        chk("midrst_cout", cout_v[0], 0);
        chk("midrst_ovf",  ovf_v[0],  0);
        repeat (8) @(negedge clk);
        launch(0, 32'hABCD, 32'h1111, 1'b1, 1);
        wait_done(0);
        @(negedge clk);

        // random vectors at WIDTH=8 and WIDTH=32, mixing DONE and IDLE starts
        for (int i = 1; i < 3; i++) begin
            for (int n = 0; n < 1000; n++) begin
                launch(i, $urandom, $urandom, 1'($urandom), 1);
                wait_done(i);
                if ($urandom_range(0, 1) == 0) @(negedge clk);
            end
            @(negedge clk);
        end

        repeat (4) @(negedge clk);
        chk("leftover_expected", qsize(0) + qsize(1) + qsize(2), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_err, n_chk);
        $fatal(1);
    end
endmodule
